// File: rtl/mc_data_path.sv
// mc_data_path: multi-cycle MIPS-subset datapath with its own controller FSM
// and a single shared instruction/data memory port (req/ready handshake).
// Instructions: add/sub/and/or/slt, addi, lw, sw, beq, j.
// Optional feature macro: MC_DATA_PATH_BNE_EN (adds bne, opcode 0x05).
module mc_data_path #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned NREGS    = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic [2:0]        state,
  output logic              retire,
  output logic              illegal
);

  localparam int unsigned RW = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    I_ALU_R, I_ADDI, I_LW, I_SW, I_BEQ, I_BNE, I_J, I_ILL
  } iclass_t;

  state_t  cur_st, nxt_st;
  iclass_t cls;
  logic    run;

  logic [31:0] ir, a, b, target, alu_out, mdr;
  logic [31:0] rf [NREGS];

  logic [5:0]    op, funct, alu_f;
  logic [RW-1:0] rs_i, rt_i, rd_i;
  logic [31:0]   imm_sx, rs_val, rt_val, alu_b, alu_res;

  logic          ir_ld, dec_ld, alu_ld, mdr_ld, pc_ld, rf_we, ret_nxt, ill_nxt;
  logic [31:0]   pc_nxt, rf_wd;
  logic [RW-1:0] rf_wa;

  assign op     = ir[31:26];
  assign funct  = ir[5:0];
  assign rs_i   = RW'(ir[25:21]);
  assign rt_i   = RW'(ir[20:16]);
  assign rd_i   = RW'(ir[15:11]);
  assign imm_sx = {{16{ir[15]}}, ir[15:0]};

  assign state     = cur_st;
  assign mem_wdata = b;

  // Register-file read ports; index 0 and out-of-range indices read as zero
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if ((rs_i != '0) && (32'(rs_i) < NREGS)) rs_val = rf[rs_i];
    if ((rt_i != '0) && (32'(rt_i) < NREGS)) rt_val = rf[rt_i];
  end

  // Instruction class decode from the held instruction register
  always_comb begin
    cls = I_ILL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT: cls = I_ALU_R;
          default:                          cls = I_ILL;
        endcase
      end
      OP_ADDI: cls = I_ADDI;
      OP_LW:   cls = I_LW;
      OP_SW:   cls = I_SW;
      OP_BEQ:  cls = I_BEQ;
`ifdef MC_DATA_PATH_BNE_EN
      OP_BNE:  cls = I_BNE;
`else
      OP_BNE:  cls = I_ILL;
`endif
      OP_J:    cls = I_J;
      default: cls = I_ILL;
    endcase
  end

  // ALU: R-type uses funct with B, everything else adds the sign-extended immediate
  always_comb begin
    alu_b   = (cls == I_ALU_R) ? b : imm_sx;
    alu_f   = (cls == I_ALU_R) ? funct : F_ADD;
    alu_res = a + alu_b;
    case (alu_f)
      F_SUB:   alu_res = a - alu_b;
      F_AND:   alu_res = a & alu_b;
      F_OR:    alu_res = a | alu_b;
      F_SLT:   alu_res = {31'b0, $signed(a) < $signed(alu_b)};
      default: alu_res = a + alu_b;
    endcase
  end

  // Controller next-state, memory port drive and datapath load strobes
  always_comb begin
    nxt_st   = cur_st;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc[ADDR_W-1:0];
    ir_ld    = 1'b0;
    dec_ld   = 1'b0;
    alu_ld   = 1'b0;
    mdr_ld   = 1'b0;
    pc_ld    = 1'b0;
    pc_nxt   = pc;
    rf_we    = 1'b0;
    rf_wa    = '0;
    rf_wd    = alu_out;
    ret_nxt  = 1'b0;
    ill_nxt  = 1'b0;
    case (cur_st)
      S_FETCH: begin
        if (run) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_ld  = 1'b1;
            pc_ld  = 1'b1;
            pc_nxt = pc + 32'd4;
            nxt_st = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        dec_ld = 1'b1;
        case (cls)
          I_J: begin
            pc_ld   = 1'b1;
            pc_nxt  = {pc[31:28], ir[25:0], 2'b00};
            ret_nxt = 1'b1;
            nxt_st  = S_FETCH;
          end
          I_ILL: begin
            ret_nxt = 1'b1;
            ill_nxt = 1'b1;
            nxt_st  = S_FETCH;
          end
          default: nxt_st = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls)
          I_ALU_R, I_ADDI: begin
            alu_ld = 1'b1;
            nxt_st = S_WB;
          end
          I_LW, I_SW: begin
            alu_ld = 1'b1;
            nxt_st = S_MEM;
          end
          I_BEQ, I_BNE: begin
            if ((a == b) == (cls == I_BEQ)) begin
              pc_ld  = 1'b1;
              pc_nxt = target;
            end
            ret_nxt = 1'b1;
            nxt_st  = S_FETCH;
          end
          default: nxt_st = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = alu_out[ADDR_W-1:0];
        mem_we   = (cls == I_SW);
        if (mem_ready) begin
          if (cls == I_SW) begin
            ret_nxt = 1'b1;
            nxt_st  = S_FETCH;
          end else begin
            mdr_ld = 1'b1;
            nxt_st = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        ret_nxt = 1'b1;
        nxt_st  = S_FETCH;
        case (cls)
          I_ALU_R: rf_wa = rd_i;
          I_LW: begin
            rf_wa = rt_i;
            rf_wd = mdr;
          end
          default: rf_wa = rt_i;
        endcase
      end
      default: nxt_st = S_FETCH;
    endcase
  end

  // FSM state, run flag and registered retire/illegal pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_st  <= S_FETCH;
      run     <= 1'b0;
      retire  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      cur_st  <= nxt_st;
      run     <= 1'b1;
      retire  <= ret_nxt;
      illegal <= ill_nxt;
    end
  end

  // Datapath holding registers: PC, IR, A/B, branch target, ALUOut, MDR
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      target  <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      if (pc_ld)  pc <= pc_nxt;
      if (ir_ld)  ir <= mem_rdata;
      if (dec_ld) begin
        a      <= rs_val;
        b      <= rt_val;
        target <= pc + {imm_sx[29:0], 2'b00};
      end
      if (alu_ld) alu_out <= alu_res;
      if (mdr_ld) mdr <= mem_rdata;
    end
  end

  // Register file write port; writes to register 0 are dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (rf_we && (rf_wa != '0) && (32'(rf_wa) < NREGS)) begin
      rf[rf_wa] <= rf_wd;
    end
  end

endmodule

// File: tb/tb_mc_data_path.sv
// tb_mc_data_path: directed program run against a word memory model with
// programmable wait states; checks cycle counts, PC, register results,
// store handshake and reset behaviour.
`timescale 1ns/1ps
module tb_mc_data_path;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        retire, illegal;

  int unsigned wait_n = 0;
  int unsigned wcnt = 0;
  int unsigned phase = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  logic [31:0] mem [0:127];

  always #5 clk = ~clk;

  mc_data_path #(
    .RESET_PC(32'h0000_0000),
    .ADDR_W(32),
    .NREGS(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .pc(pc),
    .state(state),
    .retire(retire),
    .illegal(illegal)
  );

  function automatic logic [31:0] image(input int unsigned ph, input int unsigned idx);
    logic [31:0] w;
    w = 32'h0;
    if (ph == 0) begin
      case (idx)
        0:  w = 32'h2001_0005; // addi $1,$0,5
        1:  w = 32'h2002_FFFD; // addi $2,$0,-3
        2:  w = 32'h0022_1820; // add  $3,$1,$2
        3:  w = 32'h0041_202A; // slt  $4,$2,$1
        4:  w = 32'h0022_3022; // sub  $6,$1,$2
        5:  w = 32'h0022_3824; // and  $7,$1,$2
        6:  w = 32'h0022_4025; // or   $8,$1,$2
        7:  w = 32'h0022_482A; // slt  $9,$1,$2
        8:  w = 32'hAC03_0008; // sw   $3,8($0)
        9:  w = 32'h8C05_0008; // lw   $5,8($0)
        10: w = 32'h2000_0007; // addi $0,$0,7
        11: w = 32'h0000_0000; // R-type funct 0: unsupported
        12: w = 32'h1422_0002; // opcode 0x05 $1,$2,+2 -> 0x3C
        13: w = 32'h0800_000F; // j 0x3C
        15: w = 32'h1022_0005; // beq $1,$2,+5 (not taken)
        16: w = 32'h0800_0040; // j 0x100
        64: w = 32'h1021_FFFF; // beq $1,$1,-1 at 0x100
        default: w = 32'h0;
      endcase
    end else begin
      case (idx)
        0:  w = 32'h2001_0009; // addi $1,$0,9
        1:  w = 32'h8C01_0080; // lw   $1,0x80($0)
        32: w = 32'h0000_1234;
        default: w = 32'h0;
      endcase
    end
    return w;
  endfunction

  assign mem_ready = mem_req && (wcnt == wait_n);
  assign mem_rdata = mem[mem_addr[8:2]];

  // Memory model: image load while reset is held, wait-state counter, store port
  always @(posedge clk) begin
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else                       wcnt <= 0;
    if (!reset) begin
      for (int unsigned i = 0; i < 128; i++) mem[i] <= image(phase, i);
    end else if (mem_req && mem_ready && mem_we) begin
      mem[mem_addr[8:2]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_retire(input string tag, input int exp_cyc, input logic [31:0] exp_pc,
                             input logic exp_ill, input logic chk_mem, input logic [31:0] ea,
                             input logic ew, input logic [31:0] ed);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (chk_mem && state == 3'd3 && mem_req) begin
        check({tag, "_maddr"}, mem_addr, ea);
        check({tag, "_mwe"}, {31'b0, mem_we}, {31'b0, ew});
        if (ew) check({tag, "_mwdata"}, mem_wdata, ed);
      end
    end while (!retire && cyc < 40);
    check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_illegal"}, {31'b0, illegal}, {31'b0, exp_ill});
    check({tag, "_state"}, {29'b0, state}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  seen;
    phase  = 0;
    wait_n = 0;
    reset  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_we", {31'b0, mem_we}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_state", {29'b0, state}, 32'd0);
    check("rst_retire", {31'b0, retire}, 32'd0);
    check("rst_illegal", {31'b0, illegal}, 32'd0);

    reset = 1'b1;
    #1 check("prerun_req", {31'b0, mem_req}, 32'd0);
    @(negedge clk);
    check("fetch0_req", {31'b0, mem_req}, 32'd1);
    check("fetch0_addr", mem_addr, 32'h0);
    check("fetch0_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    check("decode0_state", {29'b0, state}, 32'd1);
    check("decode0_pc", pc, 32'h4);

    wait_retire("addi1", 3, 32'h04, 1'b0, 1'b0, 0, 1'b0, 0);
    check("r1", dut.rf[1], 32'd5);
    wait_retire("addi2", 4, 32'h08, 1'b0, 1'b0, 0, 1'b0, 0);
    check("r2", dut.rf[2], 32'hFFFF_FFFD);
    wait_retire("add", 4, 32'h0C, 1'b0, 1'b0, 0, 1'b0, 0);
    check("r3", dut.rf[3], 32'd2);
    wait_retire("slt4", 4, 32'h10, 1'b0, 1'b0, 0, 1'b0, 0);
    check("r4", dut.rf[4], 32'd1);
    wait_retire("sub", 4, 32'h14, 1'b0, 1'b0, 0, 1'b0, 0);
    check("r6", dut.rf[6], 32'd8);
    wait_retire("and", 4, 32'h18, 1'b0, 1'b0, 0, 1'b0, 0);
    check("r7", dut.rf[7], 32'd5);
    wait_retire("or", 4, 32'h1C, 1'b0, 1'b0, 0, 1'b0, 0);
    check("r8", dut.rf[8], 32'hFFFF_FFFD);
    wait_retire("slt9", 4, 32'h20, 1'b0, 1'b0, 0, 1'b0, 0);
    check("r9", dut.rf[9], 32'd0);

    wait_n = 3;
    wait_retire("sw", 10, 32'h24, 1'b0, 1'b1, 32'h8, 1'b1, 32'h2);
    check("mem8", mem[2], 32'h2);
    wait_retire("lw", 11, 32'h28, 1'b0, 1'b1, 32'h8, 1'b0, 0);
    check("r5", dut.rf[5], 32'd2);
    wait_n = 0;

    wait_retire("addi_r0", 4, 32'h2C, 1'b0, 1'b0, 0, 1'b0, 0);
    check("r0", dut.rf[0], 32'd0);
    wait_retire("bad_funct", 2, 32'h30, 1'b1, 1'b0, 0, 1'b0, 0);
`ifdef MC_DATA_PATH_BNE_EN
    wait_retire("bne", 3, 32'h3C, 1'b0, 1'b0, 0, 1'b0, 0);
`else
    wait_retire("op05_illegal", 2, 32'h34, 1'b1, 1'b0, 0, 1'b0, 0);
    wait_retire("j_3c", 2, 32'h3C, 1'b0, 1'b0, 0, 1'b0, 0);
`endif
    wait_retire("beq_nt", 3, 32'h40, 1'b0, 1'b0, 0, 1'b0, 0);
    wait_retire("j_100", 2, 32'h100, 1'b0, 1'b0, 0, 1'b0, 0);
    wait_retire("beq_loop1", 3, 32'h100, 1'b0, 1'b0, 0, 1'b0, 0);
    wait_retire("beq_loop2", 3, 32'h100, 1'b0, 1'b0, 0, 1'b0, 0);

    phase  = 1;
    reset  = 1'b0;
    wait_n = 3;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_retire("p2_addi", 8, 32'h04, 1'b0, 1'b0, 0, 1'b0, 0);
    check("p2_r1", dut.rf[1], 32'd9);

    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (state == 3'd3 && mem_req) seen = 1;
    end
    check("p2_reach_mem", 32'(seen), 32'd1);
    @(negedge clk);
    check("p2_mem_wait_req", {31'b0, mem_req}, 32'd1);
    reset = 1'b0;
    #1;
    check("p2_rst_req", {31'b0, mem_req}, 32'd0);
    check("p2_rst_state", {29'b0, state}, 32'd0);
    check("p2_rst_pc", pc, 32'h0);
    check("p2_rst_r1", dut.rf[1], 32'd0);
    repeat (2) @(negedge clk);
    check("p2_hold_r1", dut.rf[1], 32'd0);
    reset = 1'b1;
    #1 check("p2_prerun_req", {31'b0, mem_req}, 32'd0);
    @(negedge clk);
    check("p2_refetch_req", {31'b0, mem_req}, 32'd1);
    check("p2_refetch_addr", mem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
